// File: rtl/read_from_sdram_if.sv
// Bus bundle for the SDRAM frame reader: trigger/frame select, Avalon-MM read
// master signals and the display-side byte FIFO write port.
interface read_from_sdram_if;
   logic        iTRIGGER;
   logic [5:0]  iFRAME_ID;
   logic        iWAIT_REQUEST;
   logic        iRD_DATA_VALID;
   logic [15:0] iRD_DATA;
   logic        oRD_REQ;
   logic [24:0] oRD_ADDR;
   logic        oDONE;
   logic        oFIFO_WR_CLK;
   logic        oFIFO_WR_REQ;
   logic [7:0]  oFIFO_WR_DATA;
   logic        iFIFO_WR_FULL;

   modport master (
      input  iTRIGGER, iFRAME_ID, iWAIT_REQUEST, iRD_DATA_VALID, iRD_DATA, iFIFO_WR_FULL,
      output oRD_REQ, oRD_ADDR, oDONE, oFIFO_WR_CLK, oFIFO_WR_REQ, oFIFO_WR_DATA
   );

   modport slave (
      output iTRIGGER, iFRAME_ID, iWAIT_REQUEST, iRD_DATA_VALID, iRD_DATA, iFIFO_WR_FULL,
      input  oRD_REQ, oRD_ADDR, oDONE, oFIFO_WR_CLK, oFIFO_WR_REQ, oFIFO_WR_DATA
   );
endinterface

// File: rtl/read_from_sdram.sv
// Avalon-MM pipelined read master: fetches one frame of 16-bit words from SDRAM
// and streams it into an 8-bit FIFO, high byte first.
module read_from_sdram #(
   parameter int unsigned FRAME_WORDS_LOG2 = 19,
   parameter int unsigned RESP_DEPTH       = 8
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   read_from_sdram_if.master bus
);
   localparam int unsigned ADDR_W = 25;
   localparam int unsigned ID_W   = 6;
   localparam int unsigned PTR_W  = $clog2(RESP_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned ISS_W  = FRAME_WORDS_LOG2 + 1;
   localparam logic [ISS_W-1:0] LAST_ISSUE = ISS_W'((1 << FRAME_WORDS_LOG2) - 1);

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_READING       = 2'd1,
      ST_DRAIN         = 2'd2,
      ST_DONE_AND_WAIT = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ISS_W-1:0]    r_issue_cnt;
   logic [CNT_W-1:0]    r_outstanding;
   logic [CNT_W-1:0]    r_buf_count;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic                r_phase;
   logic [15:0]         r_buf [RESP_DEPTH];

   logic [ADDR_W-1:0]   w_base;
   logic                w_active;
   logic                w_credit;
   logic                w_rd_req;
   logic                w_accept;
   logic                w_push;
   logic                w_fifo_wr;
   logic                w_pop;
   logic [15:0]         w_head;

   // Frame slots sit at the top of the word address space regardless of frame length.
   assign w_base    = {bus.iFRAME_ID, (ADDR_W - ID_W)'(0)};
   assign w_active  = (r_state == ST_READING) || (r_state == ST_DRAIN);
   assign w_credit  = ({1'b0, r_outstanding} + {1'b0, r_buf_count}) < (CNT_W + 1)'(RESP_DEPTH);
   // Credit cannot shrink while a request waits, so a raised request stays raised.
   assign w_rd_req  = (r_state == ST_READING) && w_credit;
   assign w_accept  = w_rd_req && !bus.iWAIT_REQUEST;
   assign w_push    = w_active && bus.iRD_DATA_VALID;
   assign w_fifo_wr = w_active && (r_buf_count != '0) && !bus.iFIFO_WR_FULL;
   assign w_pop     = w_fifo_wr && r_phase;
   assign w_head    = r_buf[r_rd_ptr];

   assign bus.oRD_REQ       = w_rd_req;
   assign bus.oRD_ADDR      = r_addr;
   assign bus.oDONE         = (r_state == ST_IDLE) || (r_state == ST_DONE_AND_WAIT);
   assign bus.oFIFO_WR_CLK  = iCLK;
   assign bus.oFIFO_WR_REQ  = w_fifo_wr;
   assign bus.oFIFO_WR_DATA = r_phase ? w_head[7:0] : w_head[15:8];

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:          if (bus.iTRIGGER) w_state_nxt = ST_READING;
         ST_READING:       if (w_accept && (r_issue_cnt == LAST_ISSUE)) w_state_nxt = ST_DRAIN;
         ST_DRAIN:         if ((r_outstanding == '0) && (r_buf_count == '0) && !r_phase)
                              w_state_nxt = ST_DONE_AND_WAIT;
         ST_DONE_AND_WAIT: if (!bus.iTRIGGER) w_state_nxt = ST_IDLE;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   // Address/issue tracking, response credit accounting and byte phase.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_addr        <= '0;
         r_issue_cnt   <= '0;
         r_outstanding <= '0;
         r_buf_count   <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_phase       <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && bus.iTRIGGER) begin
            r_addr      <= w_base;
            r_issue_cnt <= '0;
         end else if (w_accept) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_issue_cnt <= r_issue_cnt + ISS_W'(1);
         end
         r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_push);
         r_buf_count   <= r_buf_count + CNT_W'(w_push) - CNT_W'(w_pop);
         if (w_push)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_fifo_wr) r_phase  <= ~r_phase;
      end
   end

   always_ff @(posedge iCLK) begin
      if (w_push) r_buf[r_wr_ptr] <= bus.iRD_DATA;
   end

   a_no_overflow: assert property (@(posedge iCLK) disable iff (!iRST_N)
      !(w_push && !w_pop && (r_buf_count == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_read_from_sdram.sv
// Bench for read_from_sdram: Avalon slave model with programmable latency and
// waitrequest, FIFO full throttling, and address/byte scoreboards.
module tb_read_from_sdram;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   read_from_sdram_if bus ();

   read_from_sdram #(.FRAME_WORDS_LOG2(4), .RESP_DEPTH(8)) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          due;
   } resp_t;

   int          n_checks  = 0;
   int          n_errors  = 0;
   int          cyc       = 0;
   int          lat       = 2;
   int          wait_pct  = 0;
   int          full_pct  = 0;
   bit          spurious  = 1'b0;
   int          n_acc     = 0;
   logic        prev_stall = 1'b0;
   logic [24:0] prev_addr  = '0;
   logic [24:0] last_addr  = '0;
   resp_t       rq [$];
   logic [24:0] exp_addr_q [$];
   logic [7:0]  exp_byte_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slave model: drive inputs on the falling edge, then sample what the next rising edge will see.
   always begin
      @(negedge clk);
      cyc++;
      bus.iWAIT_REQUEST = ($urandom_range(0, 99) < wait_pct);
      bus.iFIFO_WR_FULL = ($urandom_range(0, 99) < full_pct);
      if (spurious) begin
         bus.iRD_DATA_VALID = 1'b1;
         bus.iRD_DATA       = 16'h1234;
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
         bus.iRD_DATA_VALID = 1'b1;
         bus.iRD_DATA       = rq[0].data;
         void'(rq.pop_front());
      end else begin
         bus.iRD_DATA_VALID = 1'b0;
         bus.iRD_DATA       = 16'h0000;
      end
      #1;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_req_held", 32'(bus.oRD_REQ), 32'd1);
            chk("stall_addr_held", 32'(bus.oRD_ADDR), 32'(prev_addr));
         end
         prev_stall = bus.oRD_REQ && bus.iWAIT_REQUEST;
         prev_addr  = bus.oRD_ADDR;
         if (bus.oRD_REQ === 1'b1 && bus.iWAIT_REQUEST === 1'b0) begin
            n_acc++;
            last_addr = bus.oRD_ADDR;
            chk("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("rd_addr", 32'(bus.oRD_ADDR), 32'(exp_addr_q.pop_front()));
            rq.push_back('{data: 16'hA000 | 16'(bus.oRD_ADDR[3:0]), due: cyc + lat});
         end
         if (bus.oFIFO_WR_REQ === 1'b1) begin
            chk("done_low_while_writing", 32'(bus.oDONE), 32'd0);
            chk("byte_expected", 32'(exp_byte_q.size() != 0), 32'd1);
            if (exp_byte_q.size() != 0) chk("fifo_byte", 32'(bus.oFIFO_WR_DATA), 32'(exp_byte_q.pop_front()));
         end
      end
   end

   task automatic start_frame(input logic [5:0] id, input int l, input int wp, input int fp);
      @(negedge clk);
      lat = l; wait_pct = wp; full_pct = fp;
      for (int k = 0; k < 16; k++) begin
         exp_addr_q.push_back({id, 19'd0} + 25'(k));
         exp_byte_q.push_back(8'hA0);
         exp_byte_q.push_back(8'(k));
      end
      bus.iFRAME_ID = id;
      bus.iTRIGGER  = 1'b1;
   endtask

   task automatic wait_acc(input int n);
      int t = 0;
      while (n_acc < n && t < 2000) begin @(posedge clk); t++; end
      chk("wait_acc_timeout", 32'(n_acc >= n), 32'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while ((exp_byte_q.size() != 0 || bus.oDONE !== 1'b1) && t < 3000) begin @(negedge clk); t++; end
      #2;
      chk("frame_bytes_left", 32'(exp_byte_q.size()), 32'd0);
      chk("frame_addrs_left", 32'(exp_addr_q.size()), 32'd0);
      chk("done_after_frame", 32'(bus.oDONE), 32'd1);
   endtask

   task automatic end_frame();
      @(negedge clk);
      bus.iTRIGGER = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int acc0;
      bus.iTRIGGER = 1'b0; bus.iFRAME_ID = '0; bus.iWAIT_REQUEST = 1'b0;
      bus.iRD_DATA_VALID = 1'b0; bus.iRD_DATA = '0; bus.iFIFO_WR_FULL = 1'b0;
      #1;
      chk("rst_rd_req", 32'(bus.oRD_REQ), 32'd0);
      chk("rst_rd_addr", 32'(bus.oRD_ADDR), 32'd0);
      chk("rst_fifo_wr", 32'(bus.oFIFO_WR_REQ), 32'd0);
      chk("rst_done", 32'(bus.oDONE), 32'd1);
      chk("fifo_wr_clk", 32'(bus.oFIFO_WR_CLK), 32'(clk));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Baseline frame, then trigger held high must not retrigger.
      acc0 = n_acc;
      start_frame(6'd3, 2, 0, 0);
      wait_done();
      chk("frame_a_accepts", 32'(n_acc - acc0), 32'd16);
      repeat (5) begin
         @(negedge clk); #2;
         chk("no_retrigger_req", 32'(bus.oRD_REQ), 32'd0);
         chk("held_done", 32'(bus.oDONE), 32'd1);
      end
      end_frame();

      // Random waitrequest, trigger dropped mid-frame.
      acc0 = n_acc;
      start_frame(6'd3, 3, 50, 0);
      wait_acc(acc0 + 5);
      @(negedge clk);
      bus.iTRIGGER = 1'b0;
      wait_done();
      chk("frame_b_accepts", 32'(n_acc - acc0), 32'd16);
      end_frame();

      // Long latency with FIFO full: credit caps outstanding reads at the buffer depth.
      acc0 = n_acc;
      start_frame(6'd3, 12, 0, 100);
      repeat (40) @(negedge clk);
      #2;
      chk("credit_limit_accepts", 32'(n_acc - acc0), 32'd8);
      chk("credit_limit_req", 32'(bus.oRD_REQ), 32'd0);
      chk("full_no_write", 32'(bus.oFIFO_WR_REQ), 32'd0);
      full_pct = 0;
      wait_done();
      chk("frame_c_accepts", 32'(n_acc - acc0), 32'd16);
      end_frame();

      // Latency 1 with random stalls on both sides: pushes, pops and accepts collide.
      acc0 = n_acc;
      start_frame(6'd10, 1, 30, 30);
      wait_done();
      chk("frame_d_accepts", 32'(n_acc - acc0), 32'd16);
      end_frame();

      // Reset at word 7 aborts the frame immediately.
      acc0 = n_acc;
      start_frame(6'd5, 3, 20, 0);
      wait_acc(acc0 + 7);
      @(posedge clk); #2;
      rst_n = 1'b0;
      rq.delete(); exp_addr_q.delete(); exp_byte_q.delete();
      bus.iTRIGGER = 1'b0;
      #1;
      chk("abort_rd_req", 32'(bus.oRD_REQ), 32'd0);
      chk("abort_rd_addr", 32'(bus.oRD_ADDR), 32'd0);
      chk("abort_fifo_wr", 32'(bus.oFIFO_WR_REQ), 32'd0);
      chk("abort_done", 32'(bus.oDONE), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Spurious readdatavalid while idle must be ignored.
      @(negedge clk);
      spurious = 1'b1;
      repeat (10) begin
         @(negedge clk); #2;
         chk("idle_no_write", 32'(bus.oFIFO_WR_REQ), 32'd0);
         chk("idle_no_req", 32'(bus.oRD_REQ), 32'd0);
      end
      spurious = 1'b0;
      repeat (2) @(negedge clk);

      // Highest frame slot.
      acc0 = n_acc;
      start_frame(6'd63, 2, 0, 0);
      wait_done();
      chk("frame_f_accepts", 32'(n_acc - acc0), 32'd16);
      chk("frame_f_last_addr", 32'(last_addr), 32'h01F8000F);
      end_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
